// File: rtl/envelope_vca_pkg.sv
// Shared widths, saturation limits and the signed saturation helper for the envelope VCA.
package envelope_vca_pkg;
  localparam int SAMPLE_W = 24;
  localparam int AMP_W    = 31;
  localparam int PROD_W   = SAMPLE_W + AMP_W + 1;

  localparam int unsigned AMP_SHIFT_DEF = 16;
  localparam int unsigned SLEW_STEP_DEF = 1024;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [AMP_W-1:0]    amp_t;
  typedef logic signed [PROD_W-1:0]   prod_t;

  typedef struct packed {
    sample_t sample;
    logic    clip;
  } sat_t;

  localparam sample_t SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam sample_t SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  function automatic sat_t sat_signed(input prod_t p);
    sat_t r;
    r.sample = p[SAMPLE_W-1:0];
    r.clip   = 1'b0;
    if (p > prod_t'(SAMPLE_MAX)) begin
      r.sample = SAMPLE_MAX;
      r.clip   = 1'b1;
    end else if (p < prod_t'(SAMPLE_MIN)) begin
      r.sample = SAMPLE_MIN;
      r.clip   = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/envelope_vca_if.sv
// Sample-stream and control bundle between the voice chain and the VCA.
interface envelope_vca_if import envelope_vca_pkg::*; ();
  amp_t    cur_amplitude;
  sample_t in_sample;
  logic    in_valid;
  logic    in_ready;
  sample_t out_sample;
  logic    out_valid;
  logic    out_ready;
  logic    clip;
  logic    idle;

  modport master (
    output cur_amplitude, in_sample, in_valid, out_ready,
    input  in_ready, out_sample, out_valid, clip, idle
  );

  modport slave (
    input  cur_amplitude, in_sample, in_valid, out_ready,
    output in_ready, out_sample, out_valid, clip, idle
  );
endinterface

// File: rtl/envelope_vca_gain_slew.sv
// Smoothed gain register: moves toward the target by at most SLEW_STEP per enabled cycle.
module envelope_vca_gain_slew
  import envelope_vca_pkg::*;
#(
  parameter int unsigned SLEW_STEP = SLEW_STEP_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  amp_t target,
  output amp_t gain
);
  localparam amp_t STEP = amp_t'(SLEW_STEP);

  amp_t gain_q, gain_d;

  always_comb begin
    gain_d = gain_q;
    if (en) begin
      if (STEP == '0) begin
        gain_d = target;
      end else if (target >= gain_q) begin
        gain_d = ((target - gain_q) <= STEP) ? target : gain_q + STEP;
      end else begin
        gain_d = ((gain_q - target) <= STEP) ? target : gain_q - STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) gain_q <= '0;
    else        gain_q <= gain_d;
  end

  assign gain = gain_q;
endmodule

// File: rtl/envelope_vca.sv
// Envelope-driven VCA: slew-limited gain, 3-stage multiply / rescale / saturate pipeline
// with a single global advance so every stage moves or holds together.
module envelope_vca
  import envelope_vca_pkg::*;
#(
  parameter int unsigned AMP_SHIFT = AMP_SHIFT_DEF,
  parameter int unsigned SLEW_STEP = SLEW_STEP_DEF
) (
  input logic           clk,
  input logic           reset,
  envelope_vca_if.slave vif
);
  logic    advance, accept;
  amp_t    gain;
  sat_t    sat;

  logic    s1_valid_q, s1_valid_d;
  sample_t s1_sample_q, s1_sample_d;
  logic    s2_valid_q, s2_valid_d;
  prod_t   s2_prod_q, s2_prod_d;
  logic    s3_valid_q, s3_valid_d;
  sample_t s3_sample_q, s3_sample_d;
  logic    s3_clip_q, s3_clip_d;

  assign advance = !s3_valid_q || vif.out_ready;
  assign accept  = vif.in_valid && advance;

  // gain only moves on accept, so it stays paired with the sample sitting in S1
  envelope_vca_gain_slew #(.SLEW_STEP(SLEW_STEP)) u_gain_slew (
    .clk    (clk),
    .reset  (reset),
    .en     (accept),
    .target (vif.cur_amplitude),
    .gain   (gain)
  );

  assign sat = sat_signed(s2_prod_q >>> AMP_SHIFT);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sample_d = s1_sample_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s3_valid_d  = s3_valid_q;
    s3_sample_d = s3_sample_q;
    s3_clip_d   = s3_clip_q;
    if (advance) begin
      s1_valid_d  = accept;
      s1_sample_d = vif.in_sample;
      s2_valid_d  = s1_valid_q;
      s2_prod_d   = prod_t'(s1_sample_q) * prod_t'($signed({1'b0, gain}));
      s3_valid_d  = s2_valid_q;
      s3_sample_d = sat.sample;
      s3_clip_d   = sat.clip && s2_valid_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s3_valid_q  <= 1'b0;
      s3_sample_q <= '0;
      s3_clip_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s3_valid_q  <= s3_valid_d;
      s3_sample_q <= s3_sample_d;
      s3_clip_q   <= s3_clip_d;
    end
  end

  assign vif.in_ready   = advance;
  assign vif.out_sample = s3_sample_q;
  assign vif.out_valid  = s3_valid_q;
  assign vif.clip       = s3_clip_q;
  assign vif.idle       = (gain == '0) && (vif.cur_amplitude == '0) &&
                          !s1_valid_q && !s2_valid_q && !s3_valid_q;
endmodule

// File: tb/tb_envelope_vca.sv
// Bench for envelope_vca: an unsmoothed and a slewed instance share one stimulus stream and
// are both scored against an arithmetic reference model.
module tb_envelope_vca;
  import envelope_vca_pkg::*;

  localparam longint SMAX = 8388607;
  localparam longint SMIN = -8388608;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  envelope_vca_if vif0 ();
  envelope_vca_if vif1 ();

  assign vif1.cur_amplitude = vif0.cur_amplitude;
  assign vif1.in_sample     = vif0.in_sample;
  assign vif1.in_valid      = vif0.in_valid;
  assign vif1.out_ready     = vif0.out_ready;

  envelope_vca #(.AMP_SHIFT(16), .SLEW_STEP(0))    u_dut0 (.clk(clk), .reset(reset), .vif(vif0));
  envelope_vca #(.AMP_SHIFT(16), .SLEW_STEP(1024)) u_dut1 (.clk(clk), .reset(reset), .vif(vif1));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint out;
    bit     clip;
  } exp_t;

  function automatic longint slew(input longint g, input longint tgt, input longint step);
    longint d;
    d = tgt - g;
    if (step == 0 || (d <= step && d >= -step)) return tgt;
    return (d > 0) ? g + step : g - step;
  endfunction

  function automatic exp_t vca(input longint s, input longint g);
    exp_t   r;
    longint prod, q;
    prod = s * g;
    q    = prod / 65536;
    if (prod < 0 && q * 65536 != prod) q = q - 1;
    r.clip = 1'b1;
    if (q > SMAX)      r.out = SMAX;
    else if (q < SMIN) r.out = SMIN;
    else begin
      r.out  = q;
      r.clip = 1'b0;
    end
    return r;
  endfunction

  exp_t   q0[$], q1[$];
  longint g0 = 0, g1 = 0;
  exp_t   e;
  bit     collect0 = 0, collect1 = 0, saw_stall = 0;
  longint col0[$], col1[$];

  always @(negedge clk) begin
    if (!reset) begin
      q0.delete(); q1.delete();
      g0 = 0; g1 = 0;
    end else begin
      check("dut0_in_ready", vif0.in_ready, !vif0.out_valid || vif0.out_ready);
      check("dut1_in_ready", vif1.in_ready, vif0.in_ready);
      check("dut0_idle", vif0.idle, (g0 == 0 && vif0.cur_amplitude == 0 && q0.size() == 0));
      check("dut1_idle", vif1.idle, (g1 == 0 && vif0.cur_amplitude == 0 && q1.size() == 0));
      if (vif0.out_valid && !vif0.out_ready && !vif0.in_ready) saw_stall = 1;
      if (vif0.out_valid && vif0.out_ready) begin
        if (q0.size() == 0) check("dut0_unexpected_output", 1, 0);
        else begin
          e = q0.pop_front();
          check("dut0_out", longint'(vif0.out_sample), e.out);
          check("dut0_clip", vif0.clip, e.clip);
        end
        if (collect0) col0.push_back(longint'(vif0.out_sample));
      end
      if (vif1.out_valid && vif1.out_ready) begin
        if (q1.size() == 0) check("dut1_unexpected_output", 1, 0);
        else begin
          e = q1.pop_front();
          check("dut1_out", longint'(vif1.out_sample), e.out);
          check("dut1_clip", vif1.clip, e.clip);
        end
        if (collect1) col1.push_back(longint'(vif1.out_sample));
      end
      if (vif0.in_valid && vif0.in_ready) begin
        g0 = slew(g0, longint'(vif0.cur_amplitude), 0);
        g1 = slew(g1, longint'(vif0.cur_amplitude), 1024);
        q0.push_back(vca(longint'(vif0.in_sample), g0));
        q1.push_back(vca(longint'(vif0.in_sample), g1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input longint s, input longint amp);
    bit ok;
    ok = 0;
    vif0.in_sample     = sample_t'(s);
    vif0.cur_amplitude = amp_t'(amp);
    vif0.in_valid      = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (vif0.in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check("send_timeout", 0, 1);
    tick();
    vif0.in_valid = 1'b0;
  endtask

  typedef struct {
    longint amp;
    longint smp;
    longint exp_out;
    bit     exp_clip;
  } vec_t;

  vec_t    vecs[11];
  sample_t rs;
  longint  gexp;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{65536,   1000,     1000,  0};
    vecs[1]  = '{32768,   -1000,    -500,  0};
    vecs[2]  = '{32768,   -1,       -1,    0};
    vecs[3]  = '{32768,   1,        0,     0};
    vecs[4]  = '{0,       -5,       0,     0};
    vecs[5]  = '{262144,  3145728,  SMAX,  1};
    vecs[6]  = '{262144,  -3145728, SMIN,  1};
    vecs[7]  = '{65536,   SMIN,     SMIN,  0};
    vecs[8]  = '{131072,  -4194304, SMIN,  0};
    vecs[9]  = '{131072,  4194304,  SMAX,  1};
    vecs[10] = '{131072,  4194303,  8388606, 0};

    vif0.cur_amplitude = '0;
    vif0.in_sample     = '0;
    vif0.in_valid      = 1'b0;
    vif0.out_ready     = 1'b1;

    #2;
    check("rst_out_valid", vif0.out_valid, 0);
    check("rst_out_sample", longint'(vif0.out_sample), 0);
    check("rst_clip", vif0.clip, 0);
    check("rst_idle", vif0.idle, 1);
    check("rst_idle_slew", vif1.idle, 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // single samples through the unsmoothed instance, including latency
    for (int i = 0; i < 11; i++) begin
      vif0.cur_amplitude = amp_t'(vecs[i].amp);
      vif0.in_sample     = sample_t'(vecs[i].smp);
      vif0.in_valid      = 1'b1;
      tick();
      vif0.in_valid = 1'b0;
      check("lat_cycle1", vif0.out_valid, 0);
      tick();
      check("lat_cycle2", vif0.out_valid, 0);
      tick();
      check("lat_cycle3_valid", vif0.out_valid, 1);
      check("vec_out", longint'(vif0.out_sample), vecs[i].exp_out);
      check("vec_clip", vif0.clip, vecs[i].exp_clip);
      tick();
    end

    // backpressure: stream 1..8, downstream stalls cycles 3..7
    col0.delete();
    collect0 = 1;
    saw_stall = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i, 65536);
      end
      begin
        for (int c = 0; c < 30; c++) begin
          vif0.out_ready = !(c >= 3 && c <= 7);
          tick();
        end
      end
    join
    collect0 = 0;
    check("bp_count", col0.size(), 8);
    for (int i = 0; i < col0.size() && i < 8; i++) check("bp_order", col0[i], i + 1);
    check("bp_in_ready_low_when_full", saw_stall, 1);

    // slew ramp up, idle gap, ramp down
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vif0.cur_amplitude = '0;
    tick();
    col1.delete();
    collect1 = 1;
    for (int k = 0; k < 64; k++) send(1000, 65536);
    vif0.cur_amplitude = '0;
    repeat (10) tick();
    check("slew_gap_not_idle", vif1.idle, 0);
    for (int k = 0; k < 64; k++) send(1000, 0);
    repeat (5) tick();
    collect1 = 0;
    check("slew_count", col1.size(), 128);
    for (int k = 1; k <= 128 && k <= col1.size(); k++) begin
      gexp = (k <= 64) ? 1024 * k : 65536 - 1024 * (k - 64);
      check("slew_out", col1[k-1], (1000 * gexp) / 65536);
    end
    check("slew_idle_end", vif1.idle, 1);
    check("fast_idle_end", vif0.idle, 1);

    // randomized traffic scored by the monitor
    for (int c = 0; c < 600; c++) begin
      rs = sample_t'($urandom);
      case ($urandom_range(0, 3))
        0:       vif0.cur_amplitude = '0;
        1:       vif0.cur_amplitude = amp_t'(65536);
        2:       vif0.cur_amplitude = amp_t'($urandom_range(0, 262144));
        default: vif0.cur_amplitude = amp_t'($urandom);
      endcase
      vif0.in_sample = rs;
      vif0.in_valid  = ($urandom_range(0, 3) != 0);
      vif0.out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    vif0.in_valid  = 1'b0;
    vif0.out_ready = 1'b1;
    repeat (5) tick();
    check("rand_drain0", q0.size(), 0);
    check("rand_drain1", q1.size(), 0);

    // reset with all three stages occupied
    vif0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(100 + i, 0);
    check("mid_full_out_valid", vif0.out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", vif0.out_valid, 0);
    check("mid_rst_out_valid_slew", vif1.out_valid, 0);
    check("mid_rst_out_sample", longint'(vif0.out_sample), 0);
    tick();
    reset = 1'b1;
    vif0.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_output", vif0.out_valid, 0);
    end
    check("post_rst_idle", vif0.idle, 1);
    check("post_rst_idle_slew", vif1.idle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
